// File: rtl/arithmetic_unit_pkg.sv
// rtl/arithmetic_unit_pkg.sv - opcode encodings shared by the arithmetic unit and the ALU decoder
package arithmetic_unit_pkg;

  typedef logic [2:0] arith_op_t;

  localparam arith_op_t OP_ADD = 3'b000;
  localparam arith_op_t OP_SUB = 3'b001;
  localparam arith_op_t OP_INC = 3'b010;
  localparam arith_op_t OP_DEC = 3'b011;
  localparam arith_op_t OP_MUL = 3'b100;

  // Everything above OP_MUL is reserved for future arithmetic ops.
  function automatic logic op_is_reserved(input arith_op_t op);
    return (op > OP_MUL);
  endfunction

endpackage

// File: rtl/arithmetic_unit_arith_core.sv
// rtl/arithmetic_unit_arith_core.sv - combinational ADD/SUB/INC/DEC/MUL datapath
module arith_core
  import arithmetic_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  input  arith_op_t               arith_op,
  output logic [DATA_WIDTH-1:0]   result,
  output logic                    carry_out,
  output logic [2*DATA_WIDTH-1:0] mult_result,
  output logic                    op_err
);

  localparam logic [DATA_WIDTH:0] ONE_EXT = {{DATA_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH:0]     a_ext;
  logic [DATA_WIDTH:0]     b_ext;
  logic [DATA_WIDTH:0]     ext;
  logic [2*DATA_WIDTH-1:0] prod;

  assign a_ext = {1'b0, a};
  assign b_ext = {1'b0, b};
  assign prod  = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};

  // The extra MSB of ext is the carry for additions and the borrow for subtractions.
  always_comb begin
    ext         = '0;
    result      = '0;
    carry_out   = 1'b0;
    mult_result = '0;
    op_err      = op_is_reserved(arith_op);
    case (arith_op)
      OP_ADD: ext = a_ext + b_ext;
      OP_SUB: ext = a_ext - b_ext;
      OP_INC: ext = a_ext + ONE_EXT;
      OP_DEC: ext = a_ext - ONE_EXT;
      default: ext = '0;
    endcase
    case (arith_op)
      OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
        result    = ext[DATA_WIDTH-1:0];
        carry_out = ext[DATA_WIDTH];
      end
      OP_MUL: begin
        mult_result = prod;
        result      = prod[DATA_WIDTH-1:0];
        carry_out   = |prod[2*DATA_WIDTH-1:DATA_WIDTH];
      end
      default: begin
        result    = '0;
        carry_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/arithmetic_unit.sv
// rtl/arithmetic_unit.sv - registered integer arithmetic unit with one-cycle latency
module arithmetic_unit
  import arithmetic_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  input  arith_op_t               arith_op,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   result,
  output logic                    carry_out,
  output logic [2*DATA_WIDTH-1:0] mult_result,
  output logic                    op_err
);

  logic [DATA_WIDTH-1:0]   core_result;
  logic                    core_carry;
  logic [2*DATA_WIDTH-1:0] core_mult;
  logic                    core_err;

  arith_core #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_arith_core (
    .a           (a),
    .b           (b),
    .arith_op    (arith_op),
    .result      (core_result),
    .carry_out   (core_carry),
    .mult_result (core_mult),
    .op_err      (core_err)
  );

  // Data registers only load on accepted operands so the last result stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      result      <= '0;
      carry_out   <= 1'b0;
      mult_result <= '0;
      op_err      <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result      <= core_result;
        carry_out   <= core_carry;
        mult_result <= core_mult;
        op_err      <= core_err;
      end
    end
  end

endmodule

// File: tb/tb_arithmetic_unit.sv
// tb/tb_arithmetic_unit.sv - self-checking bench for arithmetic_unit
module tb_arithmetic_unit;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2:0]     arith_op;
  logic           out_valid;
  logic [W-1:0]   result;
  logic           carry_out;
  logic [2*W-1:0] mult_result;
  logic           op_err;

  int checks = 0;
  int errors = 0;

  arithmetic_unit #(.DATA_WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .a           (a),
    .b           (b),
    .arith_op    (arith_op),
    .out_valid   (out_valid),
    .result      (result),
    .carry_out   (carry_out),
    .mult_result (mult_result),
    .op_err      (op_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the opcode rules.
  int m_valid, m_result, m_carry, m_mult, m_err;

  task automatic model_eval(input int op, input int x, input int y,
                            output int res, output int c, output int m, output int e);
    int s;
    res = 0; c = 0; m = 0; e = 0;
    case (op)
      0: begin s = x + y; res = s % 256; c = (s > 255); end
      1: begin res = (x - y + 256) % 256; c = (x < y); end
      2: begin res = (x + 1) % 256; c = (x == 255); end
      3: begin res = (x + 255) % 256; c = (x == 0); end
      4: begin m = x * y; res = m % 256; c = (m > 255); end
      default: e = 1;
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_result = 0; m_carry = 0; m_mult = 0; m_err = 0;
    end else if (in_valid) begin
      model_eval(int'(arith_op), int'(a), int'(b), m_result, m_carry, m_mult, m_err);
      m_valid = 1;
    end else begin
      m_valid = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("cmp_out_valid", 32'(out_valid), 32'(m_valid));
      check("cmp_result", 32'(result), 32'(m_result));
      check("cmp_carry", 32'(carry_out), 32'(m_carry));
      check("cmp_mult", 32'(mult_result), 32'(m_mult));
      check("cmp_op_err", 32'(op_err), 32'(m_err));
    end
  end

  typedef struct {
    logic [2:0]  op;
    int          x, y, er, ec, em, ee;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [2:0] op, input int x, input int y,
                         input int er, input int ec, input int em, input int ee);
    vec_t v;
    v.op = op; v.x = x; v.y = y; v.er = er; v.ec = ec; v.em = em; v.ee = ee;
    vecs.push_back(v);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_result"}, 32'(result), 0);
    check({tag, "_carry"}, 32'(carry_out), 0);
    check({tag, "_mult"}, 32'(mult_result), 0);
    check({tag, "_op_err"}, 32'(op_err), 0);
  endtask

  initial begin
    add_vec(3'b000, 200, 100,  44, 1,     0, 0);
    add_vec(3'b000, 255, 255, 254, 1,     0, 0);
    add_vec(3'b000, 128, 127, 255, 0,     0, 0);
    add_vec(3'b000,   0,   0,   0, 0,     0, 0);
    add_vec(3'b001,  50, 100, 206, 1,     0, 0);
    add_vec(3'b001,   0,   1, 255, 1,     0, 0);
    add_vec(3'b001, 100, 100,   0, 0,     0, 0);
    add_vec(3'b001,   0,   0,   0, 0,     0, 0);
    add_vec(3'b010, 255,   7,   0, 1,     0, 0);
    add_vec(3'b010,  41, 200,  42, 0,     0, 0);
    add_vec(3'b011,   0,  99, 255, 1,     0, 0);
    add_vec(3'b011,   1,   0,   0, 0,     0, 0);
    add_vec(3'b100, 255, 255,   1, 1, 65025, 0);
    add_vec(3'b100,  16,  16,   0, 1,   256, 0);
    add_vec(3'b100,   7,  11,  77, 0,    77, 0);
    add_vec(3'b101,   9,   9,   0, 0,     0, 1);
    add_vec(3'b111, 200, 100,   0, 0,     0, 1);
    add_vec(3'b000,   3,   4,   7, 0,     0, 0);

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; arith_op = 3'b000;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back directed vectors with literal expectations.
    foreach (vecs[i]) begin
      arith_op = vecs[i].op; a = W'(vecs[i].x); b = W'(vecs[i].y); in_valid = 1'b1;
      @(negedge clk);
      check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 1);
      check($sformatf("vec%0d_result", i), 32'(result), 32'(vecs[i].er));
      check($sformatf("vec%0d_carry", i), 32'(carry_out), 32'(vecs[i].ec));
      check($sformatf("vec%0d_mult", i), 32'(mult_result), 32'(vecs[i].em));
      check($sformatf("vec%0d_op_err", i), 32'(op_err), 32'(vecs[i].ee));
    end

    // Idle cycle: valid drops, data holds the last result (3+4).
    in_valid = 1'b0; a = 8'd90; b = 8'd91; arith_op = 3'b100;
    @(negedge clk);
    check("hold_out_valid", 32'(out_valid), 0);
    check("hold_result", 32'(result), 7);
    check("hold_mult", 32'(mult_result), 0);

    // Mid-stream reset clears outputs without a clock edge.
    arith_op = 3'b100; a = 8'd7; b = 8'd11; in_valid = 1'b1;
    @(negedge clk);
    check("pre_rst_mult", 32'(mult_result), 77);
    arith_op = 3'b000; a = 8'd1; b = 8'd1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    a = 8'd5; b = 8'd5;
    @(negedge clk);
    check_zero("rst_held");
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("pending_drop");

    // Short model-checked stream after reset.
    for (int k = 0; k < 12; k++) begin
      arith_op = 3'(k % 6); a = 8'(k * 37 + 3); b = 8'(k * 91 + 250); in_valid = (k % 4 != 3);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
